// File: rtl/mem_responder_if.sv
// Memory port between the datapath (master) and mem_responder (slave).
// Latency: n/a, wires only.
// Backpressure: the master holds req and its qualifiers until ack.
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        mem_err;
    logic        busy;
    logic [1:0]  state;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, mem_err, busy, state
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, mem_err, busy, state
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised 16-bit memory responder with WAIT_CYCLES wait states and fault flagging.
// Latency: req sampled at edge n -> ack during cycle n+1+WAIT_CYCLES; one access per WAIT_CYCLES+2.
// Backpressure: one access at a time; req is ignored outside IDLE. Optional macro MEM_WRITE_PROTECT_EN.
module mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] TEXT_TOP    = 16'h0200
) (
    input  logic           CLK,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [AW-1:0] r_idx;
    logic [15:0]   r_wdata;
    logic          r_fault;
    logic          r_ack;
    logic          r_err;
    logic          r_busy;
    logic [15:0]   r_rdata;
    logic [15:0]   r_mem [DEPTH];

    logic          w_wp_fault;
    logic          w_in_fault;
    logic          w_we;
    logic [AW-1:0] w_idx;
    logic          w_fault;
    logic [15:0]   w_rword;
    logic          w_enter_resp;

`ifdef MEM_WRITE_PROTECT_EN
    // The text region below TEXT_TOP is read-only to the datapath.
    assign w_wp_fault = bus.we && (bus.addr < TEXT_TOP);
`else
    logic w_unused_text_top;
    assign w_unused_text_top = &{1'b0, TEXT_TOP};
    assign w_wp_fault        = 1'b0;
`endif

    // Fault classification of the address currently on the bus.
    assign w_in_fault = bus.addr[0]
                      | ({1'b0, bus.addr[15:1]} >= 16'(DEPTH))
                      | w_wp_fault;

    // With zero wait states RESP is entered straight from IDLE, so the
    // response must be formed from the bus rather than the latched copy.
    always_comb begin
        w_we    = r_we;
        w_idx   = r_idx;
        w_fault = r_fault;
        if (r_state == S_IDLE) begin
            w_we    = bus.we;
            w_idx   = bus.addr[AW:1];
            w_fault = w_in_fault;
        end
    end

    assign w_rword = r_mem[w_idx];

    assign w_enter_resp = ((r_state == S_IDLE) && bus.req && (WAIT_CYCLES == 0))
                        || ((r_state == S_WAIT) && (r_cnt <= 4'd1));

    // Request FSM with registered ack/mem_err/busy/rdata.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 16'h0000;
            r_fault <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 16'h0000;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_idx   <= bus.addr[AW:1];
                        r_wdata <= bus.wdata;
                        r_fault <= w_in_fault;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_busy  <= 1'b1;
                        r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_enter_resp) begin
                r_ack <= 1'b1;
                r_err <= w_fault;
                if (!w_we) begin
                    r_rdata <= w_fault ? 16'h0000 : w_rword;
                end
            end
        end
    end

    // Good writes commit at the edge leaving RESP; reset at that edge drops them.
    always_ff @(posedge CLK) begin
        if (reset && (r_state == S_RESP) && r_we && !r_fault) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.ack     = r_ack;
    assign bus.mem_err = r_err;
    assign bus.busy    = r_busy;
    assign bus.rdata   = r_rdata;
    assign bus.state   = r_state;
endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a transaction-level model.
// Latency: model predicts ack WAIT_CYCLES+1 cycles after the sampling cycle.
// Backpressure: requests are held until ack, then dropped within the ack cycle.
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int          DEPTH    = 1024;
    localparam int          W        = 2;
    localparam logic [15:0] TEXT_TOP = 16'h0200;
`ifdef MEM_WRITE_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic reset = 1'b0;

    mem_responder_if bus_if();

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .TEXT_TOP(TEXT_TOP)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [15:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_started = 1'b0;
    bit          m_pend    = 1'b0;
    int          m_edge    = 0;
    int          m_acc     = 0;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    bit          m_fault;

    logic        e_ack   = 1'b0;
    logic        e_err   = 1'b0;
    logic        e_busy  = 1'b0;
    logic [1:0]  e_state = 2'd0;
    logic [15:0] e_rdata = 16'h0000;
    bit          e_rk    = 1'b1;

    function automatic bit model_fault(input logic we, input logic [15:0] a);
        bit f;
        f = (a % 2 == 1) || ((a / 2) >= DEPTH);
        f = f || (PROTECT && we && (a < TEXT_TOP));
        return f;
    endfunction

    // One access occupies edges acc .. acc+W+1; the responder is free again after that.
    initial begin
        forever begin
            bit was_free;
            int off;
            @(posedge CLK);
            m_edge++;
            m_started = 1'b1;
            if (!reset) begin
                m_pend  = 1'b0;
                e_ack   = 1'b0;
                e_err   = 1'b0;
                e_busy  = 1'b0;
                e_state = 2'd0;
                e_rdata = 16'h0000;
                e_rk    = 1'b1;
            end else begin
                was_free = !m_pend;
                if (m_pend && (m_edge == m_acc + W + 1)) begin
                    if (m_we && !m_fault) begin
                        m_mem[m_addr[10:1]]   = m_wdata;
                        m_known[m_addr[10:1]] = 1'b1;
                    end
                    m_pend = 1'b0;
                end
                if (was_free && bus_if.req) begin
                    m_pend  = 1'b1;
                    m_acc   = m_edge;
                    m_we    = bus_if.we;
                    m_addr  = bus_if.addr;
                    m_wdata = bus_if.wdata;
                    m_fault = model_fault(bus_if.we, bus_if.addr);
                end
                if (m_pend) begin
                    off     = m_edge - m_acc;
                    e_busy  = 1'b1;
                    e_state = (off < W) ? 2'd1 : 2'd2;
                    e_ack   = (off == W);
                    e_err   = e_ack && m_fault;
                    if (e_ack && !m_we) begin
                        if (m_fault) begin
                            e_rdata = 16'h0000;
                            e_rk    = 1'b1;
                        end else begin
                            e_rdata = m_mem[m_addr[10:1]];
                            e_rk    = m_known[m_addr[10:1]];
                        end
                    end
                end else begin
                    e_busy  = 1'b0;
                    e_state = 2'd0;
                    e_ack   = 1'b0;
                    e_err   = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (m_started) begin
                chk("cyc_ack",   {31'd0, bus_if.ack},     {31'd0, e_ack});
                chk("cyc_err",   {31'd0, bus_if.mem_err}, {31'd0, e_err});
                chk("cyc_busy",  {31'd0, bus_if.busy},    {31'd0, e_busy});
                chk("cyc_state", {30'd0, bus_if.state},   {30'd0, e_state});
                if (e_rk) chk("cyc_rdata", {16'd0, bus_if.rdata}, {16'd0, e_rdata});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input string nm, output logic [15:0] rd, output logic err);
        bit got;
        int lat;
        @(posedge CLK);
        #1;
        bus_if.req   = 1'b1;
        bus_if.we    = we;
        bus_if.addr  = a;
        bus_if.wdata = d;
        got = 1'b0;
        lat = 0;
        rd  = 'x;
        err = 'x;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge CLK);
            if (bus_if.ack === 1'b1) begin
                got         = 1'b1;
                lat         = n;
                rd          = bus_if.rdata;
                err         = bus_if.mem_err;
                bus_if.req  = 1'b0;
            end else if (n >= 2) begin
                // Already latched: these changes must not affect the access.
                bus_if.we    = 1'($urandom);
                bus_if.addr  = 16'($urandom);
                bus_if.wdata = 16'($urandom);
            end
        end
        bus_if.req = 1'b0;
        chk({nm, "_lat"}, lat, W + 2);
    endtask

    initial begin
        logic [15:0] rd;
        logic        err;
        logic [15:0] a;
        int          acks;
        int          waited;

        bus_if.req   = 1'b1;
        bus_if.we    = 1'b0;
        bus_if.addr  = 16'h0400;
        bus_if.wdata = 16'h0000;
        reset        = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            chk("rst_ack",   {31'd0, bus_if.ack},   32'd0);
            chk("rst_busy",  {31'd0, bus_if.busy},  32'd0);
            chk("rst_rdata", {16'd0, bus_if.rdata}, 32'd0);
            chk("rst_state", {30'd0, bus_if.state}, 32'd0);
        end
        bus_if.req = 1'b0;
        reset      = 1'b1;

        // Give the two random windows known contents.
        for (int i = 0; i < 32; i++) begin
            access(1'b1, 16'(i * 2), 16'($urandom), "pre_lo", rd, err);
            access(1'b1, 16'h0400 + 16'(i * 2), 16'($urandom), "pre_hi", rd, err);
        end

        access(1'b1, 16'h0400, 16'hBEEF, "wr_beef", rd, err);
        chk("wr_beef_err", {31'd0, err}, 32'd0);
        access(1'b0, 16'h0400, 16'h0000, "rd_beef", rd, err);
        chk("rd_beef_data", {16'd0, rd}, 32'h0000BEEF);
        chk("rd_beef_err", {31'd0, err}, 32'd0);

        access(1'b0, 16'h0401, 16'h0000, "rd_misal", rd, err);
        chk("rd_misal_err",  {31'd0, err}, 32'd1);
        chk("rd_misal_data", {16'd0, rd},  32'd0);
        access(1'b0, 16'h0800, 16'h0000, "rd_oor", rd, err);
        chk("rd_oor_err", {31'd0, err}, 32'd1);

        access(1'b1, 16'h0010, 16'h1111, "wp_old", rd, err);
        access(1'b1, 16'h0010, 16'h1234, "wp_new", rd, err);
        chk("wp_err", {31'd0, err}, {31'd0, PROTECT});
        access(1'b0, 16'h0010, 16'h0000, "wp_rd", rd, err);
        chk("wp_rd_is_new", {31'd0, (rd === 16'h1234)}, {31'd0, !PROTECT});

        // Continuous request: one ack every W+2 cycles.
        @(posedge CLK);
        #1;
        bus_if.req  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = 16'h0400;
        acks = 0;
        repeat (12) begin
            @(negedge CLK);
            if (bus_if.ack === 1'b1) acks++;
        end
        bus_if.req = 1'b0;
        chk("burst_acks", acks, 3);

        // Reset while a write sits in WAIT.
        access(1'b1, 16'h0020, 16'h5A5A, "rst_prior", rd, err);
        @(posedge CLK);
        #1;
        bus_if.req   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = 16'h0020;
        bus_if.wdata = 16'hDEAD;
        waited = 0;
        do begin
            @(negedge CLK);
            waited++;
        end while (bus_if.state !== 2'd1 && waited < 10);
        chk("rst_reached_wait", {30'd0, bus_if.state}, 32'd1);
        reset      = 1'b0;
        bus_if.req = 1'b0;
        @(negedge CLK);
        chk("midrst_state", {30'd0, bus_if.state}, 32'd0);
        chk("midrst_ack",   {31'd0, bus_if.ack},   32'd0);
        chk("midrst_busy",  {31'd0, bus_if.busy},  32'd0);
        reset = 1'b1;
        access(1'b0, 16'h0020, 16'h0000, "rst_rd", rd, err);
        chk("rst_rd_dropped", {31'd0, (rd === 16'hDEAD)}, 32'd0);
        chk("rst_rd_prior",   {31'd0, (rd === 16'h5A5A)}, {31'd0, !PROTECT});

        // Randomised traffic mixing good, misaligned and out-of-range accesses.
        repeat (150) begin
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            case ($urandom_range(0, 7))
                0:       a = 16'($urandom) | 16'h0001;
                1:       a = 16'h0800 | 16'($urandom_range(0, 1023) << 1);
                default: a = ($urandom_range(0, 1) == 1 ? 16'h0400 : 16'h0000)
                           + 16'($urandom_range(0, 31) << 1);
            endcase
            access(1'($urandom), a, 16'($urandom), "rnd", rd, err);
        end

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-organised 16-bit memory responder servicing the multicycle datapath's memory port. Accepts one read or write request at a time over a req/ack handshake, inserts a configurable number of wait states, returns read data and flags out-of-range or misaligned accesses on `mem_err`. It is the responding end of the datapath's memory interface: the datapath initiates through `memoryaddress`/`mdr`, and this block answers.

## Interface
Parameters:
- `DEPTH`, 1024: number of 16-bit words; valid byte addresses 0 .. 2*DEPTH-1.
- `WAIT_CYCLES`, 2: wait states inserted between accept and ack (0..15).
- `TEXT_TOP`, 16'h0200: first byte address above the protected text region (used only with the write-protect macro).

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset (`reset`==0 at a rising edge resets).
- `req`  in  1  access request, level; held by initiator until `ack`.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  16  byte address; bit 0 must be 0.
- `wdata`  in  16  write data; sampled with `req`.
- `ack`  out  1  one-cycle completion pulse.
- `rdata`  out  16  read data, valid when `ack` and not `mem_err`; held until the next read completes.
- `mem_err`  out  1  high with `ack` when the access faulted.
- `busy`  out  1  high from accept until the ack cycle, inclusive.
- `state`  out  2  debug: 0 IDLE, 1 WAIT, 2 RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `req`==1, latch `we`, `addr`, `wdata`; load counter with WAIT_CYCLES; go WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: decrement counter each cycle; go RESP when counter reaches 1 at the edge (i.e. exactly WAIT_CYCLES cycles spent in WAIT).
- RESP: `ack`=1 for exactly this cycle; next state IDLE unconditionally.
- Fault check on latched address: `addr[0]`==1 (misaligned) or `addr[15:1]` >= DEPTH (out of range) -> `mem_err`=1 in RESP.
- Faulted write: array unchanged. Faulted read: `rdata` set to 16'h0000.
- Good write: array[`addr[15:1]`] <= latched `wdata` at the edge ending RESP. `rdata` unchanged.
- Good read: `rdata` <= array word, loaded at the edge entering RESP.
- `req`, `we`, `addr`, `wdata` are ignored outside IDLE; changes mid-access have no effect.
- Back-to-back: a `req` still high in IDLE after RESP starts a new access; initiator must drop `req` by the end of the ack cycle to avoid a repeat.
- Array contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `ack`=0, `mem_err`=0, `busy`=0, `rdata`=16'h0000, counter 0.
- Latency: `req` sampled at edge n -> `ack` high during cycle n+1+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles with `req` held continuously.
- Read-after-write to the same word in consecutive accesses returns the new data.
- Reset mid-access (WAIT or RESP): return to IDLE, no `ack`; a pending write not yet committed is dropped.
- `ack` and `mem_err` are registered; no combinational path from inputs to outputs.

## Configuration
- `MEM_WRITE_PROTECT_EN` defined: writes to byte addresses below TEXT_TOP are faulted (`mem_err`=1 with `ack`, array unchanged); reads there are normal.
- Undefined: TEXT_TOP is ignored; all in-range aligned writes commit.

## Test plan
- Reset held low 10 cycles with `req`=1 -> `ack`=0, `busy`=0, `rdata`=0 throughout; `state`=0.
- Write 16'hBEEF to 16'h0400, then read 16'h0400 (WAIT_CYCLES=2) -> each `ack` exactly 3 cycles after `req` sampled; read returns 16'hBEEF, `mem_err`=0.
- Read addr 16'h0401 -> `ack` with `mem_err`=1, `rdata`=16'h0000; read addr 16'h0800 (DEPTH=1024) -> `mem_err`=1.
- Write 16'h1234 to 16'h0010 with `MEM_WRITE_PROTECT_EN` -> `mem_err`=1, subsequent read of 16'h0010 returns old value; without macro -> read returns 16'h1234.
- Hold `req`=1 for 12 cycles (WAIT_CYCLES=2) -> `ack` pulses every 4 cycles, 3 pulses.
- Assert reset during WAIT of a write to 16'h0020 -> no `ack`, FSM IDLE next cycle, read of 16'h0020 returns prior contents.
